// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between NumReq requesters.
// The pick is locked until the shim grants. R beats are routed back by AXI ID.
module axi_rd_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned BlenWidth = 2,
  parameter int unsigned DataWidth = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*AddrWidth-1:0] addr_i,
  input  logic [NumReq*BlenWidth-1:0] blen_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic                        rlast_o,
  output logic [DataWidth-1:0]        rdata_o,
  output logic [NumReq-1:0]           busy_o,
  output logic                        id_err_o,
  output logic                        rd_req_o,
  input  logic                        rd_gnt_i,
  output logic [AddrWidth-1:0]        rd_addr_o,
  output logic [BlenWidth-1:0]        rd_blen_o,
  output logic [IdWidth-1:0]          rd_id_o,
  input  logic                        rd_valid_i,
  input  logic                        rd_last_i,
  input  logic [IdWidth-1:0]          rd_id_i,
  input  logic [DataWidth-1:0]        rd_data_i
);

  localparam int unsigned SelW =
    (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef logic [SelW-1:0] sel_t;

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e              state_q;
  state_e              state_d;
  sel_t                sel_q;
  sel_t                sel_d;
  sel_t                rr_ptr_q;
  sel_t                rr_ptr_d;
  logic [NumReq-1:0]   busy_q;
  logic [NumReq-1:0]   busy_d;
  logic                id_err_q;
  logic                id_err_d;
  logic [NumReq-1:0]   eligible;
  logic                found;
  sel_t                pick;
  sel_t                act;
  logic                req;
  logic                grant;

  // Requests are masked during reset so no output is live while rst_ni is low.
  always_comb begin
    eligible = req_i & ~busy_q & {NumReq{rst_ni}};
    found    = 1'b0;
    pick     = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= int'(NumReq)) begin
        j = j - int'(NumReq);
      end
      if (!found && eligible[j]) begin
        found = 1'b1;
        pick  = sel_t'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    act     = pick;
    req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        act = pick;
        req = found;
        if (found && !rd_gnt_i) begin
          state_d = HOLD;
          sel_d   = pick;
        end
      end
      HOLD: begin
        act = sel_q;
        req = 1'b1;
        if (rd_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant = req & rd_gnt_i;

  always_comb begin
    rd_addr_o = '0;
    rd_blen_o = '0;
    rd_id_o   = '0;
    gnt_o     = '0;
    if (req) begin
      rd_id_o = IdWidth'(act);
      for (int i = 0; i < int'(NumReq); i++) begin
        if (act == sel_t'(i)) begin
          rd_addr_o = addr_i[i*AddrWidth +: AddrWidth];
          rd_blen_o = blen_i[i*BlenWidth +: BlenWidth];
          gnt_o[i]  = grant;
        end
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      rvalid_o[i] = rd_valid_i
                  & (rd_id_i == IdWidth'(i))
                  & busy_q[i];
    end
  end

  assign rlast_o  = rd_last_i;
  assign rdata_o  = rd_data_i;
  assign busy_o   = busy_q;
  assign id_err_o = id_err_q;
  assign rd_req_o = req;

  // Grant and clear never hit the same index: busy entries are ineligible.
  always_comb begin
    busy_d   = (busy_q | gnt_o)
             & ~(rvalid_o & {NumReq{rd_last_i}});
    id_err_d = id_err_q | (rd_valid_i & ~(|rvalid_o));
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      if (act == sel_t'(NumReq - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = act + sel_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      busy_q   <= '0;
      id_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      id_err_q <= id_err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with two requesters.
// Inputs change 2ns after each rising edge; outputs are checked 1ns later.
module tb_axi_rd_arbiter;

  localparam int NumReq    = 2;
  localparam int IdWidth   = 4;
  localparam int AddrWidth = 64;
  localparam int BlenWidth = 2;
  localparam int DataWidth = 64;

  logic                        clk;
  logic                        rst_n;
  logic [NumReq-1:0]           req;
  logic [NumReq*AddrWidth-1:0] addr;
  logic [NumReq*BlenWidth-1:0] blen;
  logic [NumReq-1:0]           gnt;
  logic [NumReq-1:0]           rvalid;
  logic                        rlast;
  logic [DataWidth-1:0]        rdata;
  logic [NumReq-1:0]           busy;
  logic                        id_err;
  logic                        rd_req;
  logic                        rd_gnt;
  logic [AddrWidth-1:0]        rd_addr;
  logic [BlenWidth-1:0]        rd_blen;
  logic [IdWidth-1:0]          rd_id;
  logic                        rd_valid;
  logic                        rd_last;
  logic [IdWidth-1:0]          rd_id_in;
  logic [DataWidth-1:0]        rd_data;

  int compared;
  int mismatched;

  localparam logic [63:0] A0 = 64'h0000_0000_8000_0040;
  localparam logic [63:0] A1 = 64'h0000_0000_9000_0100;

  axi_rd_arbiter #(
    .NumReq    (NumReq),
    .IdWidth   (IdWidth),
    .AddrWidth (AddrWidth),
    .BlenWidth (BlenWidth),
    .DataWidth (DataWidth)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .addr_i     (addr),
    .blen_i     (blen),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rlast_o    (rlast),
    .rdata_o    (rdata),
    .busy_o     (busy),
    .id_err_o   (id_err),
    .rd_req_o   (rd_req),
    .rd_gnt_i   (rd_gnt),
    .rd_addr_o  (rd_addr),
    .rd_blen_o  (rd_blen),
    .rd_id_o    (rd_id),
    .rd_valid_i (rd_valid),
    .rd_last_i  (rd_last),
    .rd_id_i    (rd_id_in),
    .rd_data_i  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [3:0] id, input logic last);
    rd_valid = 1'b1;
    rd_id_in = id;
    rd_last  = last;
  endtask

  task automatic idle_r();
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    rd_id_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n    = 1'b0;
    req      = '0;
    addr     = {A1, A0};
    blen     = {2'd3, 2'd1};
    rd_gnt   = 1'b0;
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    rd_id_in = '0;
    rd_data  = '0;
    #1;
    chk("rst_rd_req", 64'(rd_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_id_err", 64'(id_err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request granted in the same cycle
    req    = 2'b01;
    rd_gnt = 1'b1;
    #1;
    chk("t1_gnt", 64'(gnt), 64'd1);
    chk("t1_rd_req", 64'(rd_req), 64'd1);
    chk("t1_addr", rd_addr, A0);
    chk("t1_blen", 64'(rd_blen), 64'd1);
    chk("t1_id", 64'(rd_id), 64'd0);
    tick();
    req    = '0;
    rd_gnt = 1'b0;
    #1;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_nogr", 64'(gnt), 64'd0);
    tick();
    beat(4'd0, 1'b0);
    rd_data = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("t1_rv0", 64'(rvalid), 64'd1);
    chk("t1_rdata", rdata, 64'hDEAD_BEEF_0000_0001);
    tick();
    beat(4'd0, 1'b1);
    #1;
    chk("t1_rv1", 64'(rvalid), 64'd1);
    chk("t1_rlast", 64'(rlast), 64'd1);
    chk("t1_busy_hold", 64'(busy), 64'd1);
    tick();
    idle_r();
    #1;
    chk("t1_busy_clr", 64'(busy), 64'd0);
    chk("t1_no_err", 64'(id_err), 64'd0);

    // Both request from rr_ptr 0; shim grant delayed 3 cycles
    do_reset();
    req    = 2'b11;
    rd_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t2_hold_req", 64'(rd_req), 64'd1);
      chk("t2_hold_id", 64'(rd_id), 64'd0);
      chk("t2_hold_addr", rd_addr, A0);
      chk("t2_hold_gnt", 64'(gnt), 64'd0);
      tick();
    end
    rd_gnt = 1'b1;
    #1;
    chk("t2_gnt0", 64'(gnt), 64'd1);
    tick();
    req = 2'b10;
    #1;
    chk("t2_gnt1", 64'(gnt), 64'd2);
    chk("t2_id1", 64'(rd_id), 64'd1);
    chk("t2_addr1", rd_addr, A1);
    chk("t2_blen1", 64'(rd_blen), 64'd3);
    tick();
    req    = '0;
    rd_gnt = 1'b0;
    #1;
    chk("t2_busy11", 64'(busy), 64'd3);

    // Out-of-order return: id1 four beats, then id0 one beat
    for (int b = 0; b < 4; b++) begin
      beat(4'd1, b == 3);
      #1;
      chk("ooo_rv1", 64'(rvalid), 64'd2);
      tick();
    end
    beat(4'd0, 1'b1);
    #1;
    chk("ooo_busy01", 64'(busy), 64'd1);
    chk("ooo_rv0", 64'(rvalid), 64'd1);
    tick();
    idle_r();
    #1;
    chk("ooo_busy00", 64'(busy), 64'd0);

    // Fairness with bursts ending the cycle after each grant
    req    = 2'b11;
    rd_gnt = 1'b1;
    #1;
    chk("fair_g0", 64'(gnt), 64'd1);
    tick();
    beat(4'd0, 1'b1);
    #1;
    chk("fair_g1", 64'(gnt), 64'd2);
    tick();
    beat(4'd1, 1'b1);
    #1;
    chk("fair_g2", 64'(gnt), 64'd1);
    tick();
    beat(4'd0, 1'b1);
    #1;
    chk("fair_g3", 64'(gnt), 64'd2);
    tick();
    req    = '0;
    rd_gnt = 1'b0;
    beat(4'd1, 1'b1);
    #1;
    chk("fair_busy10", 64'(busy), 64'd2);
    tick();
    idle_r();
    #1;
    chk("fair_busy00", 64'(busy), 64'd0);
    chk("fair_no_err", 64'(id_err), 64'd0);

    // Stray beat with no outstanding transaction
    beat(4'd1, 1'b1);
    #1;
    chk("stray_rv", 64'(rvalid), 64'd0);
    tick();
    idle_r();
    #1;
    chk("stray_err", 64'(id_err), 64'd1);
    tick();
    tick();
    #1;
    chk("stray_sticky", 64'(id_err), 64'd1);

    // Reset while req1 sits in HOLD with req0 outstanding
    req    = 2'b01;
    rd_gnt = 1'b1;
    #1;
    chk("rh_gnt0", 64'(gnt), 64'd1);
    tick();
    req    = 2'b10;
    rd_gnt = 1'b0;
    tick();
    #1;
    chk("rh_hold_id", 64'(rd_id), 64'd1);
    chk("rh_hold_req", 64'(rd_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rh_req", 64'(rd_req), 64'd0);
    chk("rh_busy", 64'(busy), 64'd0);
    chk("rh_gnt", 64'(gnt), 64'd0);
    chk("rh_err", 64'(id_err), 64'd0);
    tick();
    rst_n = 1'b1;
    req   = 2'b11;
    #1;
    chk("rh_rr0", 64'(rd_id), 64'd0);
    req = 2'b10;
    #1;
    chk("rh_req1", 64'(rd_id), 64'd1);
    chk("rh_req1_v", 64'(rd_req), 64'd1);
    req = '0;
    beat(4'd0, 1'b1);
    #1;
    chk("rh_late_rv", 64'(rvalid), 64'd0);
    tick();
    idle_r();
    #1;
    chk("rh_late_err", 64'(id_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
